// File: rtl/front_pipe_regs.sv
// Front-end pipeline register bank for the 5-stage RV32I core: PC (F), IF/ID (D) and ID/EX (E),
// with NOP/bubble insertion, per-stage valid bits and saturating stall/flush event counters.
module front_pipe_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CTRL_W   = 12,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              StallF,
    input  logic              StallD,
    input  logic              FlushD,
    input  logic              FlushE,

    input  logic [31:0]       PCNextF,
    input  logic [31:0]       InstrF,
    input  logic [31:0]       PCPlus4F,
    output logic [31:0]       PCF,

    output logic [31:0]       InstrD,
    output logic [31:0]       PCD,
    output logic [31:0]       PCPlus4D,
    output logic              ValidD,

    input  logic [CTRL_W-1:0] CtrlD,
    input  logic [31:0]       RD1D,
    input  logic [31:0]       RD2D,
    input  logic [31:0]       ImmExtD,
    input  logic [31:0]       PCD_in,
    input  logic [4:0]        Rs1D,
    input  logic [4:0]        Rs2D,
    input  logic [4:0]        RdD,

    output logic [CTRL_W-1:0] CtrlE,
    output logic [31:0]       RD1E,
    output logic [31:0]       RD2E,
    output logic [31:0]       ImmExtE,
    output logic [31:0]       PCE,
    output logic [31:0]       PCPlus4E,
    output logic [4:0]        Rs1E,
    output logic [4:0]        Rs2E,
    output logic [4:0]        RdE,
    output logic              ValidE,

    output logic [CNT_W-1:0]  StallCount,
    output logic [CNT_W-1:0]  FlushCount
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            PCF <= RESET_PC;
        end else if (!StallF) begin
            PCF <= PCNextF;
        end
    end

    // Flush beats stall so a squashed instruction can never be held in D.
    always_ff @(posedge clk) begin
        if (reset || FlushD) begin
            InstrD   <= NOP_INSTR;
            PCD      <= 32'h0;
            PCPlus4D <= 32'h0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            InstrD   <= InstrF;
            PCD      <= PCF;
            PCPlus4D <= PCPlus4F;
            ValidD   <= 1'b1;
        end
    end

    // A bubble zeroes the register indices too, so forwarding never matches on it.
    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            CtrlE    <= '0;
            RD1E     <= 32'h0;
            RD2E     <= 32'h0;
            ImmExtE  <= 32'h0;
            PCE      <= 32'h0;
            PCPlus4E <= 32'h0;
            Rs1E     <= 5'h0;
            Rs2E     <= 5'h0;
            RdE      <= 5'h0;
            ValidE   <= 1'b0;
        end else begin
            CtrlE    <= CtrlD;
            RD1E     <= RD1D;
            RD2E     <= RD2D;
            ImmExtE  <= ImmExtD;
            PCE      <= PCD_in;
            PCPlus4E <= PCPlus4D;
            Rs1E     <= Rs1D;
            Rs2E     <= Rs2D;
            RdE      <= RdD;
            ValidE   <= ValidD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (StallF) begin
                StallCount <= satInc(StallCount);
            end
            if (FlushD) begin
                FlushCount <= satInc(FlushCount);
            end
        end
    end

endmodule
